// File: rtl/control_pipeline_pkg.sv
// Shared widths and per-stage control bundles for the ID/EX, EX/MEM and MEM/WB registers.
package control_pipeline_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int ALUCTRL_W  = 3;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_write;
    logic                  alu_src;
    logic                  reg_dst;
    logic [ALUCTRL_W-1:0]  alu_control;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
  } ctrl_e_t;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_write;
    logic [REG_ADDR_W-1:0] write_reg;
  } ctrl_m_t;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] write_reg;
  } ctrl_w_t;

  localparam ctrl_e_t BUBBLE = '0;

endpackage

// File: rtl/control_pipeline_pipe_reg.sv
// Generic pipeline register: async active-low reset, synchronous clear over data.
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (clr_i) begin
      data_q <= '0;
    end else begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/control_pipeline.sv
// Carries decoded controls from Decode to Writeback, inserts bubbles on FlushE and
// counts valid instructions leaving WB.
module control_pipeline
  import control_pipeline_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ValidD,
  input  logic                  RegWriteD,
  input  logic                  MemtoRegD,
  input  logic                  MemWriteD,
  input  logic                  ALUSrcD,
  input  logic                  RegDstD,
  input  logic [ALUCTRL_W-1:0]  ALUControlD,
  input  logic [REG_ADDR_W-1:0] RsD,
  input  logic [REG_ADDR_W-1:0] RtD,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  FlushE,
  output logic                  RegWriteE,
  output logic                  MemtoRegE,
  output logic                  MemWriteE,
  output logic                  ALUSrcE,
  output logic                  RegDstE,
  output logic [ALUCTRL_W-1:0]  ALUControlE,
  output logic [REG_ADDR_W-1:0] RsE,
  output logic [REG_ADDR_W-1:0] RtE,
  output logic [REG_ADDR_W-1:0] RdE,
  output logic [REG_ADDR_W-1:0] WriteRegE,
  output logic                  RegWriteM,
  output logic                  MemtoRegM,
  output logic                  MemWriteM,
  output logic [REG_ADDR_W-1:0] WriteRegM,
  output logic                  RegWriteW,
  output logic                  MemtoRegW,
  output logic [REG_ADDR_W-1:0] WriteRegW,
  output logic [CNT_W-1:0]      RetiredCnt
);

  ctrl_e_t e_d, e_q;
  ctrl_m_t m_d, m_q;
  ctrl_w_t w_d, w_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign e_d = '{valid: ValidD, reg_write: RegWriteD, mem_to_reg: MemtoRegD,
                 mem_write: MemWriteD, alu_src: ALUSrcD, reg_dst: RegDstD,
                 alu_control: ALUControlD, rs: RsD, rt: RtD, rd: RdD};

  // FlushE clears ID/EX to the all-zero bubble, including its valid bit.
  pipe_reg #(.W($bits(ctrl_e_t))) u_idex (
    .clk_i(CLK), .rst_ni(RST), .clr_i(FlushE), .d_i(e_d), .q_o(e_q)
  );

  assign WriteRegE = e_q.reg_dst ? e_q.rd : e_q.rt;

  assign m_d = '{valid: e_q.valid, reg_write: e_q.reg_write, mem_to_reg: e_q.mem_to_reg,
                 mem_write: e_q.mem_write, write_reg: WriteRegE};

  pipe_reg #(.W($bits(ctrl_m_t))) u_exmem (
    .clk_i(CLK), .rst_ni(RST), .clr_i(1'b0), .d_i(m_d), .q_o(m_q)
  );

  assign w_d = '{valid: m_q.valid, reg_write: m_q.reg_write, mem_to_reg: m_q.mem_to_reg,
                 write_reg: m_q.write_reg};

  pipe_reg #(.W($bits(ctrl_w_t))) u_memwb (
    .clk_i(CLK), .rst_ni(RST), .clr_i(1'b0), .d_i(w_d), .q_o(w_q)
  );

  // Wraps modulo 2^CNT_W by design; no saturation.
  assign cnt_d = cnt_q + CNT_W'(w_q.valid);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign RegWriteE   = e_q.reg_write;
  assign MemtoRegE   = e_q.mem_to_reg;
  assign MemWriteE   = e_q.mem_write;
  assign ALUSrcE     = e_q.alu_src;
  assign RegDstE     = e_q.reg_dst;
  assign ALUControlE = e_q.alu_control;
  assign RsE         = e_q.rs;
  assign RtE         = e_q.rt;
  assign RdE         = e_q.rd;
  assign RegWriteM   = m_q.reg_write;
  assign MemtoRegM   = m_q.mem_to_reg;
  assign MemWriteM   = m_q.mem_write;
  assign WriteRegM   = m_q.write_reg;
  assign RegWriteW   = w_q.reg_write;
  assign MemtoRegW   = w_q.mem_to_reg;
  assign WriteRegW   = w_q.write_reg;
  assign RetiredCnt  = cnt_q;

endmodule

// File: tb/tb_control_pipeline.sv
// Directed, table-driven bench for control_pipeline (default counter plus a 4-bit wrap instance).
module tb_control_pipeline;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       v_d, rw_d, m2r_d, mw_d, as_d, rds_d, fl;
  logic [2:0] alu_d;
  logic [4:0] rs_d, rt_d, rd_d;

  logic       rw_e, m2r_e, mw_e, as_e, rds_e, rw_m, m2r_m, mw_m, rw_w, m2r_w;
  logic [2:0] alu_e;
  logic [4:0] rs_e, rt_e, rd_e, wr_e, wr_m, wr_w;
  logic [31:0] cnt;

  logic       xrw_e, xm2r_e, xmw_e, xas_e, xrds_e, xrw_m, xm2r_m, xmw_m, xrw_w, xm2r_w;
  logic [2:0] xalu_e;
  logic [4:0] xrs_e, xrt_e, xrd_e, xwr_e, xwr_m, xwr_w;
  logic [3:0] xcnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  control_pipeline u_dut (
    .CLK(clk), .RST(rst), .ValidD(v_d), .RegWriteD(rw_d), .MemtoRegD(m2r_d),
    .MemWriteD(mw_d), .ALUSrcD(as_d), .RegDstD(rds_d), .ALUControlD(alu_d),
    .RsD(rs_d), .RtD(rt_d), .RdD(rd_d), .FlushE(fl),
    .RegWriteE(rw_e), .MemtoRegE(m2r_e), .MemWriteE(mw_e), .ALUSrcE(as_e),
    .RegDstE(rds_e), .ALUControlE(alu_e), .RsE(rs_e), .RtE(rt_e), .RdE(rd_e),
    .WriteRegE(wr_e), .RegWriteM(rw_m), .MemtoRegM(m2r_m), .MemWriteM(mw_m),
    .WriteRegM(wr_m), .RegWriteW(rw_w), .MemtoRegW(m2r_w), .WriteRegW(wr_w),
    .RetiredCnt(cnt)
  );

  control_pipeline #(.CNT_W(4)) u_wrap (
    .CLK(clk), .RST(rst), .ValidD(v_d), .RegWriteD(rw_d), .MemtoRegD(m2r_d),
    .MemWriteD(mw_d), .ALUSrcD(as_d), .RegDstD(rds_d), .ALUControlD(alu_d),
    .RsD(rs_d), .RtD(rt_d), .RdD(rd_d), .FlushE(fl),
    .RegWriteE(xrw_e), .MemtoRegE(xm2r_e), .MemWriteE(xmw_e), .ALUSrcE(xas_e),
    .RegDstE(xrds_e), .ALUControlE(xalu_e), .RsE(xrs_e), .RtE(xrt_e), .RdE(xrd_e),
    .WriteRegE(xwr_e), .RegWriteM(xrw_m), .MemtoRegM(xm2r_m), .MemWriteM(xmw_m),
    .WriteRegM(xwr_m), .RegWriteW(xrw_w), .MemtoRegW(xm2r_w), .WriteRegW(xwr_w),
    .RetiredCnt(xcnt)
  );

  // Inputs, then hand-computed E-stage expectations (x_*) for the same row.
  typedef struct packed {
    logic v, rw, m2r, mw, as_, rds;
    logic [2:0] alu;
    logic [4:0] rs, rt, rd;
    logic fl;
    logic x_rw, x_m2r, x_mw;
    logic [4:0] x_wr;
    logic x_v;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];
  int   cnt_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_E"}, {30'd0, rw_e, m2r_e, mw_e, as_e, rds_e, alu_e, rs_e, rt_e, rd_e, wr_e}, 32'd0);
    chk({tag, "_M"}, {24'd0, rw_m, m2r_m, mw_m, wr_m}, 32'd0);
    chk({tag, "_W"}, {25'd0, rw_w, m2r_w, wr_w}, 32'd0);
    chk({tag, "_cnt"}, cnt, 32'd0);
    chk({tag, "_wrap_any"}, {31'd0, |{xrw_e, xm2r_e, xmw_e, xas_e, xrds_e, xalu_e, xrs_e, xrt_e,
        xrd_e, xwr_e, xrw_m, xm2r_m, xmw_m, xwr_m, xrw_w, xm2r_w, xwr_w, xcnt}}, 32'd0);
  endtask

  task automatic drive(input vec_t t);
    v_d = t.v; rw_d = t.rw; m2r_d = t.m2r; mw_d = t.mw; as_d = t.as_; rds_d = t.rds;
    alu_d = t.alu; rs_d = t.rs; rt_d = t.rt; rd_d = t.rd; fl = t.fl;
  endtask

  initial begin
    vec_t z;
    z = '0;
    //              v  rw m2r mw as rds alu     rs     rt     rd    fl  xrw xm2r xmw xwr   xv
    vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,3'b010,5'd1, 5'd2, 5'd3, 1'b0,1'b1,1'b0,1'b0,5'd3, 1'b1}; // add $3,$1,$2
    vecs[1]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,3'b010,5'd4, 5'd5, 5'd0, 1'b0,1'b1,1'b1,1'b0,5'd5, 1'b1}; // lw $5,0($4)
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,3'b010,5'd5, 5'd6, 5'd0, 1'b1,1'b0,1'b0,1'b0,5'd0, 1'b0}; // sw flushed
    vecs[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,3'b010,5'd5, 5'd6, 5'd0, 1'b0,1'b0,1'b0,1'b1,5'd6, 1'b1}; // sw reissued
    vecs[4]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,3'b110,5'd8, 5'd9, 5'd7, 1'b0,1'b1,1'b0,1'b0,5'd7, 1'b1};
    vecs[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,3'b000,5'd11,5'd12,5'd10,1'b0,1'b1,1'b0,1'b0,5'd10,1'b1};
    vecs[6]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,3'b001,5'd14,5'd15,5'd13,1'b0,1'b1,1'b0,1'b0,5'd13,1'b1};
    vecs[7]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,3'b111,5'd17,5'd18,5'd16,1'b0,1'b1,1'b0,1'b0,5'd16,1'b1};
    vecs[8]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,3'b010,5'd19,5'd20,5'd0, 1'b0,1'b1,1'b1,1'b0,5'd20,1'b1};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,3'b110,5'd1, 5'd2, 5'd0, 1'b0,1'b0,1'b0,1'b0,5'd2, 1'b1}; // beq
    vecs[10] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,3'b010,5'd30,5'd29,5'd31,1'b0,1'b1,1'b0,1'b0,5'd31,1'b1};
    for (int k = 11; k < NV; k++) vecs[k] = '0;

    // Reset asserted from time 0: outputs must read 0 before any clock edge.
    drive(z);
    #1;
    chk_all_zero("reset_t0");
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    cnt_exp = 0;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      if (i >= 3) cnt_exp += int'(vecs[i-3].x_v);
      chk($sformatf("E_rw[%0d]", i), {31'd0, rw_e}, {31'd0, vecs[i].x_rw});
      chk($sformatf("E_m2r[%0d]", i), {31'd0, m2r_e}, {31'd0, vecs[i].x_m2r});
      chk($sformatf("E_mw[%0d]", i), {31'd0, mw_e}, {31'd0, vecs[i].x_mw});
      chk($sformatf("E_wr[%0d]", i), {27'd0, wr_e}, {27'd0, vecs[i].x_wr});
      chk($sformatf("E_misc[%0d]", i), {13'd0, as_e, rds_e, alu_e, rs_e, rt_e, rd_e},
          vecs[i].fl ? 32'd0 : {13'd0, vecs[i].as_, vecs[i].rds, vecs[i].alu,
                                vecs[i].rs, vecs[i].rt, vecs[i].rd});
      if (i >= 1)
        chk($sformatf("M[%0d]", i), {24'd0, rw_m, m2r_m, mw_m, wr_m},
            {24'd0, vecs[i-1].x_rw, vecs[i-1].x_m2r, vecs[i-1].x_mw, vecs[i-1].x_wr});
      else
        chk("M[0]", {24'd0, rw_m, m2r_m, mw_m, wr_m}, 32'd0);
      if (i >= 2)
        chk($sformatf("W[%0d]", i), {25'd0, rw_w, m2r_w, wr_w},
            {25'd0, vecs[i-2].x_rw, vecs[i-2].x_m2r, vecs[i-2].x_wr});
      else
        chk($sformatf("W[%0d]", i), {25'd0, rw_w, m2r_w, wr_w}, 32'd0);
      chk($sformatf("cnt[%0d]", i), cnt, cnt_exp);
    end
    chk("stream_retired", cnt, 32'd10);
    chk("stream_retired_wrap", {28'd0, xcnt}, 32'd10);

    // Mid-operation asynchronous reset pulse between edges.
    @(negedge clk);
    drive(vecs[0]);
    @(posedge clk);
    #1;
    chk("pre_pulse_rwE", {31'd0, rw_e}, 32'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 chk_all_zero("pulse_low");
    drive(z);
    #1 rst = 1'b1;
    #1 chk_all_zero("pulse_released");

    // 16 back-to-back retirements: 4-bit counter reads 15 then wraps to 0.
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      drive(vecs[0]);
      v_d = (e <= 16);
      @(posedge clk);
      #1;
      if (e == 18) begin
        chk("wrap_15", {28'd0, xcnt}, 32'd15);
        chk("main_15", cnt, 32'd15);
      end
      if (e == 19) begin
        chk("wrap_0", {28'd0, xcnt}, 32'd0);
        chk("main_16", cnt, 32'd16);
      end
      if (e == 20) begin
        chk("wrap_hold0", {28'd0, xcnt}, 32'd0);
        chk("main_hold16", cnt, 32'd16);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
